// File: rtl/cdma_multiuser_link.sv
// -----------------------------------------------------------------------------
// cdma_multiuser_link
//
// Multi-user CDMA link. One frame per user is spread with that user's chip
// code and all users are summed into a single signed channel sample stream.
// The receiver correlates the stream against each user's code and decides
// every data bit by the sign of the correlation.
//
// Ports
//   CLOCK_50         single clock, all logic on the rising edge
//   rst_n            synchronous active-low reset
//   tx_data          frame to send, bit b of user u at [u*FRAME_BITS+b]
//   chip_codes       spreading codes, chip c of user u at [u*CHIP_LEN+c]
//   loopback         1: receiver listens to tx_sample, 0: to rx_sample
//   tx_valid         frame offered (must be held until accepted)
//   tx_ready         frame can be accepted (transmitter idle)
//   tx_sample        signed channel sum, SW bits
//   tx_sample_valid  tx_sample carries a chip
//   rx_sample        signed external channel sample, SW bits
//   rx_sample_valid  rx_sample carries a chip
//   rx_data          last decoded frame, same layout as tx_data
//   rx_valid         one-cycle pulse when rx_data is updated
//   busy             transmitter is in SYNC or SPREAD
// -----------------------------------------------------------------------------
module cdma_multiuser_link #(
   parameter int NUM_USERS   = 2,
   parameter int CHIP_LEN    = 4,
   parameter int FRAME_BITS  = 4,
   parameter int SYNC_CYCLES = 2,
   localparam int SW = $clog2(NUM_USERS + 1) + 1
) (
   input  logic                            CLOCK_50,
   input  logic                            rst_n,
   input  logic [NUM_USERS*FRAME_BITS-1:0] tx_data,
   input  logic [NUM_USERS*CHIP_LEN-1:0]   chip_codes,
   input  logic                            loopback,
   input  logic                            tx_valid,
   output logic                            tx_ready,
   output logic [SW-1:0]                   tx_sample,
   output logic                            tx_sample_valid,
   input  logic [SW-1:0]                   rx_sample,
   input  logic                            rx_sample_valid,
   output logic [NUM_USERS*FRAME_BITS-1:0] rx_data,
   output logic                            rx_valid,
   output logic                            busy
);

   // Accumulator holds CHIP_LEN samples of magnitude <= NUM_USERS plus sign.
   localparam int AW = SW + $clog2(CHIP_LEN) + 1;
   localparam int CW = $clog2(CHIP_LEN);
   localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int YW = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;

   localparam logic [CW-1:0] CHIP_LAST = CW'(CHIP_LEN - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);
   localparam logic [YW-1:0] SYNC_LAST = YW'((SYNC_CYCLES > 0) ? SYNC_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_SPREAD
   } tx_state_t;

   tx_state_t state, state_next;
   logic      accept;

   // Per-user views of the input buses and the latched frame.
   logic [FRAME_BITS-1:0] tx_data_u    [NUM_USERS];
   logic [CHIP_LEN-1:0]   chip_codes_u [NUM_USERS];
   logic [FRAME_BITS-1:0] data_q       [NUM_USERS];
   logic [CHIP_LEN-1:0]   codes_q      [NUM_USERS];
   logic                  loop_q;

   logic [YW-1:0] sync_cnt;
   logic [CW-1:0] tx_chip;
   logic [BW-1:0] tx_bit;
   logic [SW-1:0] chip_sum;

   // Receiver state.
   logic                  rx_active;
   logic [CW-1:0]         rx_chip;
   logic [BW-1:0]         rx_bit;
   logic signed [AW-1:0]  acc       [NUM_USERS];
   logic signed [AW-1:0]  acc_next  [NUM_USERS];
   logic [FRAME_BITS-1:0] rx_bits   [NUM_USERS];
   logic [FRAME_BITS-1:0] bits_next [NUM_USERS];
   logic [NUM_USERS*FRAME_BITS-1:0] bits_flat;

   logic [SW-1:0]        rx_in;
   logic                 rx_in_valid;
   logic                 rx_take;
   logic signed [AW-1:0] samp_ext;

   for (genvar g = 0; g < NUM_USERS; g++) begin : g_user_bus
      assign tx_data_u[g]    = tx_data[g*FRAME_BITS +: FRAME_BITS];
      assign chip_codes_u[g] = chip_codes[g*CHIP_LEN +: CHIP_LEN];
      assign bits_flat[g*FRAME_BITS +: FRAME_BITS] = bits_next[g];
   end

   // ---------------------------------------------------------------- TX FSM
   always_ff @(posedge CLOCK_50) begin
      // NOTE: every register here is assigned with <= so all of them update
      // from the same pre-edge values, whatever order the statements are in.
      if (!rst_n) begin
         state    <= ST_IDLE;
         sync_cnt <= '0;
         tx_chip  <= '0;
         tx_bit   <= '0;
         loop_q   <= 1'b0;
         for (int u = 0; u < NUM_USERS; u++) begin
            data_q[u]  <= '0;
            codes_q[u] <= '0;
         end
      end else begin
         state <= state_next;
         if (accept) begin
            loop_q   <= loopback;
            sync_cnt <= '0;
            tx_chip  <= '0;
            tx_bit   <= '0;
            for (int u = 0; u < NUM_USERS; u++) begin
               data_q[u]  <= tx_data_u[u];
               codes_q[u] <= chip_codes_u[u];
            end
         end
         if (state == ST_SYNC) begin
            sync_cnt <= sync_cnt + 1'b1;
         end
         // Chip index is the inner loop, bit index the outer loop.
         if (state == ST_SPREAD) begin
            if (tx_chip == CHIP_LAST) begin
               tx_chip <= '0;
               tx_bit  <= (tx_bit == BIT_LAST) ? '0 : tx_bit + 1'b1;
            end else begin
               tx_chip <= tx_chip + 1'b1;
            end
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default before the case so no
      // path leaves a value unassigned, which would otherwise infer a latch.
      state_next = state;
      tx_ready   = 1'b0;
      busy       = 1'b1;
      accept     = 1'b0;
      case (state)
         ST_IDLE: begin
            tx_ready = 1'b1;
            busy     = 1'b0;
            if (tx_valid) begin
               accept     = 1'b1;
               state_next = (SYNC_CYCLES == 0) ? ST_SPREAD : ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (sync_cnt == SYNC_LAST) begin
               state_next = ST_SPREAD;
            end
         end
         ST_SPREAD: begin
            if ((tx_chip == CHIP_LAST) && (tx_bit == BIT_LAST)) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------- Spreading
   // sym = data ^ chip maps 1 -> +1 and 0 -> -1; the sum is kept in two's
   // complement and SW is wide enough for -NUM_USERS..+NUM_USERS.
   always_comb begin
      chip_sum = '0;
      for (int u = 0; u < NUM_USERS; u++) begin
         if (data_q[u][tx_bit] ^ codes_q[u][tx_chip]) begin
            chip_sum = chip_sum + SW'(1);
         end else begin
            chip_sum = chip_sum - SW'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         tx_sample       <= '0;
         tx_sample_valid <= 1'b0;
      end else begin
         tx_sample       <= (state == ST_SPREAD) ? chip_sum : '0;
         tx_sample_valid <= (state == ST_SPREAD);
      end
   end

   // ----------------------------------------------------------- Despreading
   assign rx_in       = loop_q ? tx_sample : rx_sample;
   assign rx_in_valid = loop_q ? tx_sample_valid : rx_sample_valid;
   // Samples outside an accepted frame are dropped.
   assign rx_take     = rx_active & rx_in_valid;
   assign samp_ext    = {{(AW - SW){rx_in[SW-1]}}, rx_in};

   // Correlate: chip 0 adds the sample, chip 1 subtracts it, so a user whose
   // data bit is 1 builds a positive sum. Decision is made on the value that
   // includes the current sample, so the last chip is never lost.
   always_comb begin
      for (int u = 0; u < NUM_USERS; u++) begin
         acc_next[u]  = codes_q[u][rx_chip] ? acc[u] - samp_ext : acc[u] + samp_ext;
         bits_next[u] = rx_bits[u];
         bits_next[u][rx_bit] = ~acc_next[u][AW-1] && (acc_next[u] != '0);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         rx_active <= 1'b0;
         rx_chip   <= '0;
         rx_bit    <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         // NOTE: the accumulators and partial bits are real state that must
         // start at zero, so they are reset like any other register.
         for (int u = 0; u < NUM_USERS; u++) begin
            acc[u]     <= '0;
            rx_bits[u] <= '0;
         end
      end else begin
         rx_valid <= 1'b0;
         if (rx_take) begin
            if (rx_chip == CHIP_LAST) begin
               rx_chip <= '0;
               for (int u = 0; u < NUM_USERS; u++) begin
                  acc[u]     <= '0;
                  rx_bits[u] <= bits_next[u];
               end
               if (rx_bit == BIT_LAST) begin
                  rx_bit    <= '0;
                  rx_data   <= bits_flat;
                  rx_valid  <= 1'b1;
                  rx_active <= 1'b0;
               end else begin
                  rx_bit <= rx_bit + 1'b1;
               end
            end else begin
               rx_chip <= rx_chip + 1'b1;
               for (int u = 0; u < NUM_USERS; u++) begin
                  acc[u] <= acc_next[u];
               end
            end
         end
         // A new frame restarts the receiver; in loopback the previous frame's
         // last sample is consumed on this same edge, so completion still fires.
         if (accept) begin
            rx_active <= 1'b1;
            rx_chip   <= '0;
            rx_bit    <= '0;
            for (int u = 0; u < NUM_USERS; u++) begin
               acc[u] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cdma_multiuser_link.sv
// -----------------------------------------------------------------------------
// tb_cdma_multiuser_link
//
// Scoreboard bench. Drivers push expected chip samples and decoded frames into
// queues when a frame is accepted; negedge monitors pop and compare whenever
// the DUT raises tx_sample_valid or rx_valid. Instance "a" uses the default
// 2-user link, instance "b" a 4-user link with Walsh codes.
//
// Codes used with instance a: user0 chips c0..c3 = 0,0,1,1 and user1 chips
// c0..c3 = 0,1,0,1, i.e. chip_codes = {4'b1010, 4'b1100} = 8'hAC.
// -----------------------------------------------------------------------------
module tb_cdma_multiuser_link;

   logic CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   logic rst_n;

   // Instance a: NUM_USERS=2, SW=3
   logic [7:0] tx_data, chip_codes, rx_data;
   logic       loopback, tx_valid, tx_ready, tx_sample_valid;
   logic       rx_sample_valid, rx_valid, busy;
   logic [2:0] tx_sample, rx_sample;

   // Instance b: NUM_USERS=4, SW=4
   logic [15:0] b_tx_data, b_chip_codes, b_rx_data;
   logic        b_loopback, b_tx_valid, b_tx_ready, b_tx_sample_valid;
   logic        b_rx_sample_valid, b_rx_valid, b_busy;
   logic [3:0]  b_tx_sample, b_rx_sample;

   cdma_multiuser_link dut_a (
      .CLOCK_50(CLOCK_50), .rst_n(rst_n),
      .tx_data(tx_data), .chip_codes(chip_codes), .loopback(loopback),
      .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_sample(tx_sample), .tx_sample_valid(tx_sample_valid),
      .rx_sample(rx_sample), .rx_sample_valid(rx_sample_valid),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
   );

   cdma_multiuser_link #(.NUM_USERS(4)) dut_b (
      .CLOCK_50(CLOCK_50), .rst_n(rst_n),
      .tx_data(b_tx_data), .chip_codes(b_chip_codes), .loopback(b_loopback),
      .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
      .tx_sample(b_tx_sample), .tx_sample_valid(b_tx_sample_valid),
      .rx_sample(b_rx_sample), .rx_sample_valid(b_rx_sample_valid),
      .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy)
   );

   typedef struct {
      int val;
      int cyc;
   } samp_exp_t;

   typedef struct {
      int data;
      int cyc;   // required cycle of rx_valid, -1 = not checked
      int ext;   // required count of fed external samples, -1 = not checked
   } frame_exp_t;

   samp_exp_t  txq[$];
   samp_exp_t  btxq[$];
   frame_exp_t rxq[$];
   frame_exp_t brxq[$];

   int n_cmp   = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int ext_fed = 0;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   // Hand-computed chip sums for codes 8'hAC, indexed by (user0 bit, user1 bit).
   function automatic int hand_sum2(input bit d0, input bit d1, input int c);
      int p[4];
      case ({d1, d0})
         2'b11:   p = '{ 2,  0,  0, -2};
         2'b01:   p = '{ 0,  2, -2,  0};
         2'b10:   p = '{ 0, -2,  2,  0};
         default: p = '{-2,  0,  0,  2};
      endcase
      return p[c];
   endfunction

   // ---------------------------------------------------------------- monitors
   always @(negedge CLOCK_50) begin : mon_a
      samp_exp_t  se;
      frame_exp_t fe;
      if (tx_sample_valid === 1'b1) begin
         if (txq.size() == 0) fail_now("a_tx_unexpected");
         else begin
            se = txq.pop_front();
            check("a_tx_sample", int'($signed(tx_sample)), se.val);
            check("a_tx_cycle", cyc, se.cyc);
         end
      end
      if (rx_valid === 1'b1) begin
         if (rxq.size() == 0) fail_now("a_rx_unexpected");
         else begin
            fe = rxq.pop_front();
            check("a_rx_data", int'(rx_data), fe.data);
            if (fe.cyc >= 0) check("a_rx_cycle", cyc, fe.cyc);
            if (fe.ext >= 0) check("a_rx_ext_count", ext_fed, fe.ext);
         end
      end
   end

   always @(negedge CLOCK_50) begin : mon_b
      samp_exp_t  se;
      frame_exp_t fe;
      if (b_tx_sample_valid === 1'b1) begin
         if (btxq.size() == 0) fail_now("b_tx_unexpected");
         else begin
            se = btxq.pop_front();
            check("b_tx_sample", int'($signed(b_tx_sample)), se.val);
            check("b_tx_cycle", cyc, se.cyc);
         end
      end
      if (b_rx_valid === 1'b1) begin
         if (brxq.size() == 0) fail_now("b_rx_unexpected");
         else begin
            fe = brxq.pop_front();
            check("b_rx_data", int'(b_rx_data), fe.data);
            check("b_rx_cycle", cyc, fe.cyc);
         end
      end
   end

   // ----------------------------------------------------------------- drivers
   // Offers a frame on instance a. While busy, scrambled data/codes/loopback
   // are presented to show nothing is latched before the real accept.
   task automatic send_frame(input logic [7:0] d, input logic [7:0] c, input bit lb,
                             input bit hold, output int t_acc, output int low);
      low   = 0;
      t_acc = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge CLOCK_50);
         tx_valid = 1'b1;
         if (tx_ready === 1'b1) begin
            tx_data    = d;
            chip_codes = c;
            loopback   = lb;
            t_acc      = cyc + 1;
            for (int b = 0; b < 4; b++)
               for (int k = 0; k < 4; k++)
                  txq.push_back('{hand_sum2(d[b], d[4+b], k), t_acc + 3 + b*4 + k});
            if (lb) rxq.push_back('{int'(d), t_acc + 19, -1});
            else    rxq.push_back('{int'(d), -1, 16});
            @(posedge CLOCK_50);
            if (!hold) #1 tx_valid = 1'b0;
            return;
         end
         low++;
         tx_data    = ~d;
         chip_codes = ~c;
         loopback   = ~lb;
      end
      fail_now("accept_timeout");
   endtask

   task automatic wait_drain(input int limit);
      for (int n = 0; n < limit; n++) begin
         if (txq.size() == 0 && rxq.size() == 0 && btxq.size() == 0 && brxq.size() == 0)
            return;
         @(negedge CLOCK_50);
      end
      fail_now("drain_timeout");
   endtask

   initial begin
      int t1, t2, low1, low2;
      logic [7:0] ext_d;

      rst_n = 1'b0;
      tx_data = '0; chip_codes = '0; loopback = 1'b0; tx_valid = 1'b0;
      rx_sample = '0; rx_sample_valid = 1'b0;
      b_tx_data = '0; b_chip_codes = '0; b_loopback = 1'b0; b_tx_valid = 1'b0;
      b_rx_sample = '0; b_rx_sample_valid = 1'b0;

      // Reset state
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check("rst_tx_ready", int'(tx_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_tx_sample", int'(tx_sample), 0);
      check("rst_tx_sample_valid", int'(tx_sample_valid), 0);
      check("rst_rx_data", int'(rx_data), 0);
      check("rst_rx_valid", int'(rx_valid), 0);
      check("rst_b_tx_ready", int'(b_tx_ready), 1);
      rst_n = 1'b1;

      // Loopback frame: u0 bits b0..b3 = 1,1,0,1; u1 bits = 0,1,1,0
      send_frame(8'h6B, 8'hAC, 1'b1, 1'b0, t1, low1);
      check("idle_accept_wait", low1, 0);
      wait_drain(200);

      // Back-to-back frames with tx_valid held; first bit of 8'h95 has both users at 1
      send_frame(8'h95, 8'hAC, 1'b1, 1'b1, t1, low1);
      send_frame(8'h3E, 8'hAC, 1'b1, 1'b0, t2, low2);
      check("b2b_ready_low_cycles", low2, 18);
      check("b2b_accept_gap", t2 - t1, 19);
      wait_drain(200);

      // External mode: stray samples while idle, then one sample every 4 cycles
      rx_sample_valid = 1'b1;
      rx_sample = 3'b010;
      repeat (5) @(negedge CLOCK_50);
      rx_sample_valid = 1'b0;
      ext_d = 8'hC5;
      send_frame(ext_d, 8'hAC, 1'b0, 1'b0, t1, low1);
      ext_fed = 0;
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge CLOCK_50);
            rx_sample = 3'(hand_sum2(ext_d[b], ext_d[4+b], k));
            rx_sample_valid = 1'b1;
            ext_fed++;
            @(negedge CLOCK_50);
            rx_sample_valid = 1'b0;
            repeat (2) @(negedge CLOCK_50);
         end
      end
      wait_drain(200);

      // Reset in the middle of SPREAD while chip 7 is being produced
      send_frame(8'h5A, 8'hAC, 1'b1, 1'b0, t1, low1);
      while (cyc < t1 + 9) @(negedge CLOCK_50);
      rst_n = 1'b0;
      @(posedge CLOCK_50);
      txq.delete();
      rxq.delete();
      @(negedge CLOCK_50);
      check("midrst_tx_ready", int'(tx_ready), 1);
      check("midrst_busy", int'(busy), 0);
      check("midrst_tx_sample", int'(tx_sample), 0);
      check("midrst_tx_sample_valid", int'(tx_sample_valid), 0);
      check("midrst_rx_data", int'(rx_data), 0);
      check("midrst_rx_valid", int'(rx_valid), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      send_frame(8'hD2, 8'hAC, 1'b1, 1'b0, t1, low1);
      wait_drain(200);

      // Four users, Walsh codes 0000,0101,0011,0110 (c0 first), all data 1:
      // each bit spreads to 4,0,0,0
      @(negedge CLOCK_50);
      b_tx_data    = 16'hFFFF;
      b_chip_codes = 16'h6CA0;
      b_loopback   = 1'b1;
      b_tx_valid   = 1'b1;
      check("b_ready_before_accept", int'(b_tx_ready), 1);
      t1 = cyc + 1;
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 4; k++)
            btxq.push_back('{(k == 0) ? 4 : 0, t1 + 3 + b*4 + k});
      brxq.push_back('{16'hFFFF, t1 + 19, -1});
      @(posedge CLOCK_50);
      #1 b_tx_valid = 1'b0;
      wait_drain(200);

      repeat (4) @(negedge CLOCK_50);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
